// File: rtl/hazard_ctl_if.sv
// Hazard controller port bundle: ID/EX hazard fields and memory status in,
// PC and pipeline-register controls out. Optional stall counter: HAZ_STALL_CNT_EN.
interface hazard_ctl_if #(
  parameter int CNT_WIDTH = 16
);
  logic [4:0]           rs_id_87;
  logic [4:0]           rt_id_87;
  logic                 use_rs_id_87;
  logic                 use_rt_id_87;
  logic                 mem_rd_ex_87;
  logic [4:0]           wreg_ex_87;
  logic                 branch_taken_ex_87;
  logic                 jump_ex_87;
  logic                 dmem_busy_87;
  logic                 pc_en_87;
  logic                 ifid_en_87;
  logic                 idex_en_87;
  logic                 exmem_en_87;
  logic                 memwb_en_87;
  logic                 ifid_flush_87;
  logic                 idex_flush_87;
  logic                 pc_sel_87;
  logic [1:0]           state_87;
  logic [CNT_WIDTH-1:0] stall_cnt_87;

  // Datapath side: supplies hazard information, consumes pipeline controls.
  modport master (
    output rs_id_87, rt_id_87, use_rs_id_87, use_rt_id_87, mem_rd_ex_87,
           wreg_ex_87, branch_taken_ex_87, jump_ex_87, dmem_busy_87,
    input  pc_en_87, ifid_en_87, idex_en_87, exmem_en_87, memwb_en_87,
           ifid_flush_87, idex_flush_87, pc_sel_87, state_87, stall_cnt_87
  );

  modport slave (
    input  rs_id_87, rt_id_87, use_rs_id_87, use_rt_id_87, mem_rd_ex_87,
           wreg_ex_87, branch_taken_ex_87, jump_ex_87, dmem_busy_87,
    output pc_en_87, ifid_en_87, idex_en_87, exmem_en_87, memwb_en_87,
           ifid_flush_87, idex_flush_87, pc_sel_87, state_87, stall_cnt_87
  );
endinterface

// File: rtl/hazard_ctl.sv
// 5-stage pipeline hazard/stall controller; Mealy outputs, zero latency, freezes all stages on dmem_busy.
// Optional saturating stall-cycle counter enabled by HAZ_STALL_CNT_EN (port tied to 0 otherwise).
module hazard_ctl #(
  parameter int START_CYC = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic         clk_87,
  input  logic         rst_87,
  hazard_ctl_if.slave  hz
);

  typedef enum logic [1:0] {
    INIT   = 2'b00,
    RUN    = 2'b01,
    BUBBLE = 2'b10,
    WAIT   = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] init_cnt_q, init_cnt_d;

  logic redirect;
  logic load_use;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, pc_sel;

  assign redirect = hz.branch_taken_ex_87 | hz.jump_ex_87;
  assign load_use = hz.mem_rd_ex_87 && (hz.wreg_ex_87 != 5'd0) &&
                    ((hz.use_rs_id_87 && (hz.rs_id_87 == hz.wreg_ex_87)) ||
                     (hz.use_rt_id_87 && (hz.rt_id_87 == hz.wreg_ex_87)));

  always_ff @(posedge clk_87 or negedge rst_87) begin
    if (!rst_87) begin
      state_q    <= INIT;
      init_cnt_q <= 4'(START_CYC - 1);
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pc_sel     = 1'b0;
    case (state_q)
      INIT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (init_cnt_q == 4'd0) state_d = RUN;
        else                    init_cnt_d = init_cnt_q - 4'd1;
      end
      default: begin
        if (hz.dmem_busy_87) begin
          state_d = WAIT;
        end else if (redirect) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          pc_sel     = 1'b1;
          state_d    = RUN;
        // In BUBBLE the hazard's producer has already been separated by the bubble.
        end else if (load_use && (state_q != BUBBLE)) begin
          {idex_en, exmem_en, memwb_en} = 3'b111;
          idex_flush = 1'b1;
          state_d    = BUBBLE;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          state_d = RUN;
        end
      end
    endcase
  end

  assign hz.pc_en_87      = pc_en;
  assign hz.ifid_en_87    = ifid_en;
  assign hz.idex_en_87    = idex_en;
  assign hz.exmem_en_87   = exmem_en;
  assign hz.memwb_en_87   = memwb_en;
  assign hz.ifid_flush_87 = ifid_flush;
  assign hz.idex_flush_87 = idex_flush;
  assign hz.pc_sel_87     = pc_sel;
  assign hz.state_87      = state_q;

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  always_ff @(posedge clk_87 or negedge rst_87) begin
    if (!rst_87) begin
      stall_cnt_q <= '0;
    end else if ((state_q != INIT) && !pc_en && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign hz.stall_cnt_87 = stall_cnt_q;
`else
  assign hz.stall_cnt_87 = '0;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Self-checking bench for hazard_ctl: directed scenarios plus a randomized run against a cycle model.
// Works with and without HAZ_STALL_CNT_EN; a CNT_WIDTH=4 instance checks counter saturation.
module tb_hazard_ctl;
  localparam int START_CYC = 2;
`ifdef HAZ_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  // Packed output order: {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, pc_sel}
  localparam logic [7:0] O_INIT   = 8'b00000_11_0;
  localparam logic [7:0] O_FREEZE = 8'b00000_00_0;
  localparam logic [7:0] O_RUN    = 8'b11111_00_0;
  localparam logic [7:0] O_REDIR  = 8'b11111_11_1;
  localparam logic [7:0] O_LU     = 8'b00111_01_0;

  logic clk_87 = 1'b0;
  logic rst_87 = 1'b0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk_87 = ~clk_87;

  hazard_ctl_if #(.CNT_WIDTH(16)) hz ();
  hazard_ctl_if #(.CNT_WIDTH(4))  hz4 ();

  hazard_ctl #(.START_CYC(START_CYC), .CNT_WIDTH(16)) dut (
    .clk_87(clk_87), .rst_87(rst_87), .hz(hz.slave));
  hazard_ctl #(.START_CYC(START_CYC), .CNT_WIDTH(4)) dut4 (
    .clk_87(clk_87), .rst_87(rst_87), .hz(hz4.slave));

  assign hz4.rs_id_87           = hz.rs_id_87;
  assign hz4.rt_id_87           = hz.rt_id_87;
  assign hz4.use_rs_id_87       = hz.use_rs_id_87;
  assign hz4.use_rt_id_87       = hz.use_rt_id_87;
  assign hz4.mem_rd_ex_87       = hz.mem_rd_ex_87;
  assign hz4.wreg_ex_87         = hz.wreg_ex_87;
  assign hz4.branch_taken_ex_87 = hz.branch_taken_ex_87;
  assign hz4.jump_ex_87         = hz.jump_ex_87;
  assign hz4.dmem_busy_87       = hz.dmem_busy_87;

  function automatic logic [7:0] outs();
    return {hz.pc_en_87, hz.ifid_en_87, hz.idex_en_87, hz.exmem_en_87, hz.memwb_en_87,
            hz.ifid_flush_87, hz.idex_flush_87, hz.pc_sel_87};
  endfunction

  task automatic tick();
    @(posedge clk_87);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_in();
    hz.rs_id_87 = '0; hz.rt_id_87 = '0; hz.use_rs_id_87 = 0; hz.use_rt_id_87 = 0;
    hz.mem_rd_ex_87 = 0; hz.wreg_ex_87 = '0; hz.branch_taken_ex_87 = 0;
    hz.jump_ex_87 = 0; hz.dmem_busy_87 = 0;
  endtask

  task automatic reset_to_run();
    clear_in();
    rst_87 = 0;
    tick(); tick();
    rst_87 = 1;
    tick(); tick();
  endtask

  task automatic test_reset();
    clear_in();
    rst_87 = 0;
    tick(); settle();
    checks++; if (hz.state_87 !== 2'b00) $display("FAIL rst_state: got %b want 00", hz.state_87); else passes++;
    checks++; if (outs() !== O_INIT) $display("FAIL rst_outs: got %b want %b", outs(), O_INIT); else passes++;
    checks++; if (hz.stall_cnt_87 !== 16'd0) $display("FAIL rst_cnt: got %0d want 0", hz.stall_cnt_87); else passes++;
    rst_87 = 1;
    settle();
    checks++; if ({hz.state_87, outs()} !== {2'b00, O_INIT}) $display("FAIL init_cyc0: got %b want %b", {hz.state_87, outs()}, {2'b00, O_INIT}); else passes++;
    tick(); settle();
    checks++; if ({hz.state_87, outs()} !== {2'b00, O_INIT}) $display("FAIL init_cyc1: got %b want %b", {hz.state_87, outs()}, {2'b00, O_INIT}); else passes++;
    tick(); settle();
    checks++; if ({hz.state_87, outs()} !== {2'b01, O_RUN}) $display("FAIL init_cyc2: got %b want %b", {hz.state_87, outs()}, {2'b01, O_RUN}); else passes++;
  endtask

  task automatic test_load_use();
    reset_to_run();
    hz.mem_rd_ex_87 = 1; hz.wreg_ex_87 = 5'd8; hz.rt_id_87 = 5'd8; hz.use_rt_id_87 = 1;
    settle();
    checks++; if ({hz.state_87, outs()} !== {2'b01, O_LU}) $display("FAIL lu_stall: got %b want %b", {hz.state_87, outs()}, {2'b01, O_LU}); else passes++;
    tick(); settle();
    checks++; if ({hz.state_87, outs()} !== {2'b10, O_RUN}) $display("FAIL lu_bubble: got %b want %b", {hz.state_87, outs()}, {2'b10, O_RUN}); else passes++;
    clear_in();
    tick(); settle();
    checks++; if (hz.state_87 !== 2'b01) $display("FAIL lu_back_run: got %b want 01", hz.state_87); else passes++;
    hz.mem_rd_ex_87 = 1; hz.wreg_ex_87 = 5'd0; hz.rt_id_87 = 5'd0; hz.use_rt_id_87 = 1;
    settle();
    checks++; if (outs() !== O_RUN) $display("FAIL lu_r0: got %b want %b", outs(), O_RUN); else passes++;
    clear_in();
    hz.mem_rd_ex_87 = 1; hz.wreg_ex_87 = 5'd5; hz.rs_id_87 = 5'd5; hz.use_rs_id_87 = 0;
    settle();
    checks++; if (outs() !== O_RUN) $display("FAIL lu_rs_unused: got %b want %b", outs(), O_RUN); else passes++;
    hz.use_rs_id_87 = 1;
    settle();
    checks++; if (outs() !== O_LU) $display("FAIL lu_rs: got %b want %b", outs(), O_LU); else passes++;
    clear_in();
  endtask

  task automatic test_redirect();
    reset_to_run();
    hz.branch_taken_ex_87 = 1;
    hz.mem_rd_ex_87 = 1; hz.wreg_ex_87 = 5'd3; hz.rs_id_87 = 5'd3; hz.use_rs_id_87 = 1;
    settle();
    checks++; if (outs() !== O_REDIR) $display("FAIL redir_outs: got %b want %b", outs(), O_REDIR); else passes++;
    tick(); settle();
    checks++; if (hz.state_87 !== 2'b01) $display("FAIL redir_state: got %b want 01", hz.state_87); else passes++;
    clear_in();
  endtask

  task automatic test_mem_wait();
    reset_to_run();
    hz.dmem_busy_87 = 1; hz.jump_ex_87 = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if ({hz.state_87, outs()} !== {(i == 0) ? 2'b01 : 2'b11, O_FREEZE})
        $display("FAIL wait_freeze%0d: got %b want %b", i, {hz.state_87, outs()}, {(i == 0) ? 2'b01 : 2'b11, O_FREEZE}); else passes++;
      tick();
    end
    hz.dmem_busy_87 = 0;
    settle();
    checks++; if ({hz.state_87, outs()} !== {2'b11, O_REDIR}) $display("FAIL wait_release: got %b want %b", {hz.state_87, outs()}, {2'b11, O_REDIR}); else passes++;
    clear_in();
    tick(); settle();
    checks++; if (hz.state_87 !== 2'b01) $display("FAIL wait_after: got %b want 01", hz.state_87); else passes++;
    checks++; if (hz.stall_cnt_87 !== (CNT_ON ? 16'd3 : 16'd0)) $display("FAIL wait_cnt: got %0d want %0d", hz.stall_cnt_87, CNT_ON ? 3 : 0); else passes++;
  endtask

  task automatic test_reset_mid_wait();
    reset_to_run();
    hz.dmem_busy_87 = 1;
    tick(); settle();
    checks++; if (hz.state_87 !== 2'b11) $display("FAIL mid_wait_pre: got %b want 11", hz.state_87); else passes++;
    rst_87 = 0;
    #1;
    checks++; if ({hz.state_87, outs()} !== {2'b00, O_INIT}) $display("FAIL mid_wait_async: got %b want %b", {hz.state_87, outs()}, {2'b00, O_INIT}); else passes++;
    checks++; if (hz.stall_cnt_87 !== 16'd0) $display("FAIL mid_wait_cnt: got %0d want 0", hz.stall_cnt_87); else passes++;
    hz.dmem_busy_87 = 0;
    tick();
    rst_87 = 1;
    settle();
    checks++; if (hz.state_87 !== 2'b00) $display("FAIL mid_wait_init0: got %b want 00", hz.state_87); else passes++;
    tick(); settle();
    checks++; if (hz.state_87 !== 2'b00) $display("FAIL mid_wait_init1: got %b want 00", hz.state_87); else passes++;
    tick(); settle();
    checks++; if ({hz.state_87, outs()} !== {2'b01, O_RUN}) $display("FAIL mid_wait_run: got %b want %b", {hz.state_87, outs()}, {2'b01, O_RUN}); else passes++;
  endtask

  task automatic test_saturation();
    reset_to_run();
    hz.dmem_busy_87 = 1;
    repeat (20) tick();
    settle();
    checks++; if (hz4.stall_cnt_87 !== (CNT_ON ? 4'd15 : 4'd0)) $display("FAIL sat_cnt4: got %0d want %0d", hz4.stall_cnt_87, CNT_ON ? 15 : 0); else passes++;
    checks++; if (hz.stall_cnt_87 !== (CNT_ON ? 16'd20 : 16'd0)) $display("FAIL sat_cnt16: got %0d want %0d", hz.stall_cnt_87, CNT_ON ? 20 : 0); else passes++;
    clear_in();
  endtask

  // Model: INIT lasts START_CYC cycles; a stall cycle is remembered so the next
  // cycle ignores load-use; a busy cycle makes the next cycle report WAIT.
  task automatic test_random();
    int         init_left;
    bit         prev_busy, prev_lu, in_init, busy, redir, lu, in_rst;
    int         stalls;
    logic [7:0] exp_o;
    logic [1:0] exp_s;
    clear_in();
    rst_87 = 0;
    tick();
    rst_87 = 1;
    init_left = START_CYC; prev_busy = 0; prev_lu = 0; stalls = 0;
    for (int c = 0; c < 400; c++) begin
      in_rst = ($urandom_range(0, 99) == 0);
      rst_87 = !in_rst;
      hz.rs_id_87 = 5'($urandom_range(0, 3));
      hz.rt_id_87 = 5'($urandom_range(0, 3));
      hz.wreg_ex_87 = 5'($urandom_range(0, 3));
      hz.use_rs_id_87 = 1'($urandom_range(0, 1));
      hz.use_rt_id_87 = 1'($urandom_range(0, 1));
      hz.mem_rd_ex_87 = 1'($urandom_range(0, 1));
      hz.branch_taken_ex_87 = ($urandom_range(0, 9) == 0);
      hz.jump_ex_87 = ($urandom_range(0, 11) == 0);
      hz.dmem_busy_87 = ($urandom_range(0, 3) == 0);
      settle();
      if (in_rst) begin
        init_left = START_CYC; prev_busy = 0; prev_lu = 0; stalls = 0;
      end
      busy  = hz.dmem_busy_87;
      redir = hz.branch_taken_ex_87 || hz.jump_ex_87;
      lu    = hz.mem_rd_ex_87 && hz.wreg_ex_87 != 0 &&
              ((hz.use_rs_id_87 && hz.rs_id_87 == hz.wreg_ex_87) ||
               (hz.use_rt_id_87 && hz.rt_id_87 == hz.wreg_ex_87));
      in_init = (init_left > 0);
      if (in_init)          begin exp_o = O_INIT; exp_s = 2'b00; end
      else begin
        exp_s = prev_busy ? 2'b11 : (prev_lu ? 2'b10 : 2'b01);
        if (busy)                 exp_o = O_FREEZE;
        else if (redir)           exp_o = O_REDIR;
        else if (lu && !prev_lu)  exp_o = O_LU;
        else                      exp_o = O_RUN;
      end
      checks++; if ({hz.state_87, outs()} !== {exp_s, exp_o})
        $display("FAIL rand_c%0d: got %b want %b", c, {hz.state_87, outs()}, {exp_s, exp_o}); else passes++;
      checks++; if (hz.stall_cnt_87 !== (CNT_ON ? 16'(stalls) : 16'd0))
        $display("FAIL rand_cnt_c%0d: got %0d want %0d", c, hz.stall_cnt_87, CNT_ON ? stalls : 0); else passes++;
      checks++; if (hz4.stall_cnt_87 !== (CNT_ON ? 4'((stalls > 15) ? 15 : stalls) : 4'd0))
        $display("FAIL rand_cnt4_c%0d: got %0d want %0d", c, hz4.stall_cnt_87, CNT_ON ? ((stalls > 15) ? 15 : stalls) : 0); else passes++;
      if (!in_rst) begin
        if (!in_init && !exp_o[7]) stalls++;
        prev_busy = !in_init && busy;
        prev_lu   = !in_init && !busy && !redir && lu && !prev_lu;
        if (in_init) init_left--;
      end
      tick();
    end
    rst_87 = 1;
    clear_in();
  endtask

  initial begin
    clear_in();
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctl.md
# hazard_ctl

Pipeline hazard and stall controller for the 5-stage MIPS datapath. It watches the ID and EX stage register fields, the EX-stage branch/jump outcome and the data-memory busy flag. It drives the PC enable, the per-stage pipeline-register enables and flushes, and the PC redirect select. A small FSM sequences reset start-up, load-use bubbles and memory wait freezes. An optional counter accumulates stall cycles.

## Interface
- `START_CYC`, default 2: cycles the pipeline is held flushed after reset release (1..15).
- `CNT_WIDTH`, default 16: width of the stall counter.

Ports:
- `clk_87`  in  1  clock; all state changes on its rising edge.
- `rst_87`  in  1  reset; asynchronous, active-low.
- `rs_id_87`  in  5  rs field of the instruction in ID.
- `rt_id_87`  in  5  rt field of the instruction in ID.
- `use_rs_id_87`  in  1  ID instruction reads rs.
- `use_rt_id_87`  in  1  ID instruction reads rt.
- `mem_rd_ex_87`  in  1  EX instruction is a load.
- `wreg_ex_87`  in  5  destination register of the EX instruction.
- `branch_taken_ex_87`  in  1  branch in EX resolved taken.
- `jump_ex_87`  in  1  jump in EX.
- `dmem_busy_87`  in  1  data memory cannot complete the MEM-stage access this cycle.
- `pc_en_87`  out  1  PC register enable.
- `ifid_en_87`, `idex_en_87`, `exmem_en_87`, `memwb_en_87`  out  1 each  pipeline register enables.
- `ifid_flush_87`, `idex_flush_87`  out  1 each  load a bubble (all zeros) into the register; has priority over the enable.
- `pc_sel_87`  out  1  1 = PC loads the EX branch/jump target.
- `state_87`  out  2  current FSM state, for debug.
- `stall_cnt_87`  out  CNT_WIDTH  stall cycle count.

## Operation
FSM states are INIT=2'b00, RUN=2'b01, BUBBLE=2'b10 and WAIT=2'b11. Outputs are Mealy: combinational from the state and the current inputs.

Definitions:
- `redirect` = `branch_taken_ex_87` | `jump_ex_87`.
- `load_use` = `mem_rd_ex_87` & (`wreg_ex_87` != 0) & ((`use_rs_id_87` & `rs_id_87` == `wreg_ex_87`) | (`use_rt_id_87` & `rt_id_87` == `wreg_ex_87`)).

INIT:
- All enables 0; `ifid_flush_87` = `idex_flush_87` = 1; `pc_sel_87` = 0.
- A down-counter is loaded with START_CYC-1 on reset. The state moves to RUN when the counter is 0; otherwise the counter decrements.

RUN, with rules evaluated in priority order:
1. `dmem_busy_87`: all enables 0, flushes 0, `pc_sel_87` 0. Next state WAIT.
2. `redirect`: all enables 1, `pc_sel_87` 1, `ifid_flush_87` = `idex_flush_87` = 1. Next state RUN.
3. `load_use`: `pc_en_87` = `ifid_en_87` = 0, `idex_flush_87` = 1, other enables 1. Next state BUBBLE.
4. Otherwise: all enables 1, no flush. Next state RUN.

BUBBLE:
- Applies rules 1, 2 and 4 only. `load_use` is ignored, because the bubble now occupies EX.
- The next state is WAIT for rule 1, otherwise RUN.

WAIT:
- While `dmem_busy_87` = 1: full freeze as in rule 1, and the state stays WAIT.
- In the cycle `dmem_busy_87` falls, rules 2–4 apply exactly as in RUN, and the next state follows those rules.
- `redirect` or `load_use` present during the freeze are held by the frozen registers. They are acted on in the release cycle, never lost.

Asserting reset at any time returns the block to INIT with the counter reloaded. This includes mid-WAIT and mid-BUBBLE.

## Timing
- Reset values while `rst_87` = 0:
  - `state_87` = 00.
  - All enables 0.
  - `ifid_flush_87` = `idex_flush_87` = 1.
  - `pc_sel_87` = 0.
  - `stall_cnt_87` = 0.
- Outputs respond to inputs in the same cycle, with zero latency. The state updates at the next edge.
- After reset release, the first cycle with `pc_en_87` = 1 is edge START_CYC. With START_CYC = 2 the block sits in INIT for cycles 0 and 1, and cycle 2 is RUN.
- A load-use stall costs exactly 1 cycle. A redirect costs 2 flushed slots and 0 stall cycles.
- A memory wait of N busy cycles freezes all stages for exactly N cycles.

## Configuration
- `HAZ_STALL_CNT_EN` defined:
  - `stall_cnt_87` increments on each edge where the state is not INIT and `pc_en_87` = 0.
  - It saturates at 2^CNT_WIDTH-1 and clears only on reset.
- `HAZ_STALL_CNT_EN` undefined: `stall_cnt_87` is tied to 0, no counter flops exist, and the port remains.

## Test plan
- Reset release with START_CYC = 2: `state_87` reads 00 for 2 cycles, then 01. `pc_en_87` is first 1 on cycle 2, and the flushes are 1 during INIT.
- `mem_rd_ex_87` = 1, `wreg_ex_87` = 8, `rt_id_87` = 8, `use_rt_id_87` = 1: for one cycle `pc_en_87` = `ifid_en_87` = 0 and `idex_flush_87` = 1, then BUBBLE, then RUN. Repeat with `wreg_ex_87` = 0: no stall.
- `branch_taken_ex_87` = 1 together with a `load_use` condition: `pc_sel_87` = 1, both flushes 1, `pc_en_87` = 1, and the state stays RUN (redirect wins).
- `dmem_busy_87` high for 3 cycles with `jump_ex_87` = 1 held: 3 frozen cycles in WAIT, then `pc_sel_87` = 1 on the release cycle. With `HAZ_STALL_CNT_EN`, the count increases by 3.
- `rst_87` asserted mid-WAIT: the outputs immediately take their reset values without waiting for a clock edge, and after release the block follows the INIT sequence again.
- CNT_WIDTH = 4 with `HAZ_STALL_CNT_EN` and 20 busy cycles: `stall_cnt_87` holds at 15.
